// File: rtl/tx_frame_buffer.sv
// rtl/tx_frame_buffer.sv - store-and-forward transmit frame buffer
//
// Purpose:
//   Holds frame words from the NIC core until the frame's last-flagged word has
//   been written. Only then do its words become visible to the AXI-s transmitter
//   stage. A frame that grows past DEPTH words without a last flag is rewound
//   and dropped. The remaining words of that frame are acknowledged and thrown
//   away until its last word arrives.
//
// Optional feature:
//   TX_FRAME_BUFFER_STATS_EN - adds output drop_count[15:0]. It counts frames
//   that enter DROP and saturates at 0xFFFF.
//
// Ports:
//   clk             - single clock, rising edge
//   resetn          - asynchronous active-low reset
//   write_pipe_data - {last, data[N-1:0], keep[S-1:0]} from the NIC core
//   write_pipe_req  - producer offers write_pipe_data
//   write_pipe_ack  - word accepted (transfer when req & ack)
//   read_pipe_data  - head word toward the transmitter
//   read_pipe_req   - downstream requests a word
//   read_pipe_ack   - read_pipe_data valid and consumed this cycle
//   drop_count      - (STATS_EN only) saturating dropped-frame counter

module tx_frame_buffer #(
    parameter int N  = 64,
    parameter int S  = N / 8,
    parameter int D  = N + S + 1,
    parameter int AW = 6
) (
`ifdef TX_FRAME_BUFFER_STATS_EN
    output logic [15:0]  drop_count,
`endif
    input  logic         clk,
    input  logic         resetn,
    input  logic [D-1:0] write_pipe_data,
    input  logic         write_pipe_req,
    output logic         write_pipe_ack,
    output logic [D-1:0] read_pipe_data,
    input  logic         read_pipe_req,
    output logic         read_pipe_ack
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] DEPTH_P = {1'b1, {AW{1'b0}}};

    typedef enum logic {
        ACCEPT = 1'b0,
        DROP   = 1'b1
    } state_t;

    logic [D-1:0] r_mem [DEPTH];

    state_t      r_state;
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic [AW:0] r_commit_ptr;
    logic [AW:0] r_frame_cnt;
    logic [AW:0] r_cur_len;

    logic        w_full;
    logic        w_wr_fire;
    logic        w_wr_last;
    logic        w_commit;
    logic        w_rd_last;
    logic        w_overflow;
    logic [AW:0] w_wr_ptr_inc;
    logic [AW:0] w_cur_len_inc;

    // Pointers are one bit wider than the address. The difference therefore
    // distinguishes full (DEPTH) from empty (0).
    assign w_full        = (r_wr_ptr - r_rd_ptr) == DEPTH_P;
    assign w_wr_ptr_inc  = r_wr_ptr + 1'b1;
    assign w_cur_len_inc = r_cur_len + 1'b1;

    // In DROP every offered word is swallowed. Words do not occupy storage
    // there, so fullness is irrelevant. The resetn gate keeps the producer
    // from seeing an ack while reset is held.
    always_comb begin
        write_pipe_ack = 1'b0;
        if (resetn) begin
            if (r_state == DROP) begin
                write_pipe_ack = write_pipe_req;
            end else begin
                write_pipe_ack = write_pipe_req & ~w_full;
            end
        end
    end

    assign read_pipe_data = r_mem[r_rd_ptr[AW-1:0]];
    assign read_pipe_ack  = read_pipe_req & (r_frame_cnt != '0);

    assign w_wr_fire  = write_pipe_req & write_pipe_ack;
    assign w_wr_last  = write_pipe_data[D-1];
    assign w_rd_last  = read_pipe_ack & read_pipe_data[D-1];
    assign w_commit   = (r_state == ACCEPT) & w_wr_fire & w_wr_last;
    assign w_overflow = (r_state == ACCEPT) & w_wr_fire & ~w_wr_last &
                        (w_cur_len_inc == DEPTH_P);

    // Storage is not reset. The word that overflows a frame is written too,
    // which is harmless because wr_ptr rewinds over it.
    always_ff @(posedge clk) begin
        if ((r_state == ACCEPT) && w_wr_fire) begin
            r_mem[r_wr_ptr[AW-1:0]] <= write_pipe_data;
        end
    end

`ifdef TX_FRAME_BUFFER_STATS_EN
    logic [15:0] r_drop_count;
    assign drop_count = r_drop_count;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= ACCEPT;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_commit_ptr <= '0;
            r_frame_cnt  <= '0;
            r_cur_len    <= '0;
`ifdef TX_FRAME_BUFFER_STATS_EN
            r_drop_count <= '0;
`endif
        end else begin
            if (read_pipe_ack) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end

            // A commit and a last-word read in the same cycle cancel out.
            case ({w_commit, w_rd_last})
                2'b10:   r_frame_cnt <= r_frame_cnt + 1'b1;
                2'b01:   r_frame_cnt <= r_frame_cnt - 1'b1;
                default: r_frame_cnt <= r_frame_cnt;
            endcase

            case (r_state)
                ACCEPT: begin
                    if (w_wr_fire) begin
                        if (w_wr_last) begin
                            r_wr_ptr     <= w_wr_ptr_inc;
                            r_commit_ptr <= w_wr_ptr_inc;
                            r_cur_len    <= '0;
                        end else if (w_overflow) begin
                            // Rewind over the partial frame. This frees the
                            // space it held.
                            r_wr_ptr  <= r_commit_ptr;
                            r_cur_len <= '0;
                            r_state   <= DROP;
`ifdef TX_FRAME_BUFFER_STATS_EN
                            if (r_drop_count != 16'hFFFF) begin
                                r_drop_count <= r_drop_count + 16'd1;
                            end
`endif
                        end else begin
                            r_wr_ptr  <= w_wr_ptr_inc;
                            r_cur_len <= w_cur_len_inc;
                        end
                    end
                end
                DROP: begin
                    if (w_wr_fire && w_wr_last) begin
                        r_state <= ACCEPT;
                    end
                end
                default: r_state <= ACCEPT;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_frame_buffer.sv
// tb/tb_tx_frame_buffer.sv - self-checking scoreboard bench for tx_frame_buffer

module tb_tx_frame_buffer;

    localparam int N  = 64;
    localparam int S  = 8;
    localparam int D  = N + S + 1;
    localparam int AW = 6;

    logic         clk;
    logic         resetn;
    logic [D-1:0] wr_data;
    logic         wr_req;
    logic         wr_ack;
    logic [D-1:0] rd_data;
    logic         rd_req;
    logic         rd_ack;
`ifdef TX_FRAME_BUFFER_STATS_EN
    logic [15:0]  drop_count;
`endif

    tx_frame_buffer #(.N(N), .S(S), .D(D), .AW(AW)) dut (
`ifdef TX_FRAME_BUFFER_STATS_EN
        .drop_count      (drop_count),
`endif
        .clk             (clk),
        .resetn          (resetn),
        .write_pipe_data (wr_data),
        .write_pipe_req  (wr_req),
        .write_pipe_ack  (wr_ack),
        .read_pipe_data  (rd_data),
        .read_pipe_req   (rd_req),
        .read_pipe_ack   (rd_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int rd_count = 0;
    logic [D-1:0] sb [$];

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [D-1:0] mk(input bit last, input logic [63:0] data);
        return {last, data, 8'hFF};
    endfunction

    // Read-side scoreboard: every consumed word must match the oldest stored word.
    always @(negedge clk) begin
        if (resetn && rd_ack) begin
            if (sb.size() == 0) begin
                check("rd_unexpected", 80'(rd_data), 80'(0));
            end else begin
                logic [D-1:0] exp_w;
                exp_w = sb.pop_front();
                check("rd_data", 80'(rd_data), 80'(exp_w));
            end
            rd_count++;
        end
    end

    // Offers one word, waits (bounded) for acceptance, returns 1 ns after the capturing edge.
    task automatic send_word(input logic [D-1:0] w, input bit store);
        int t = 0;
        wr_data = w;
        wr_req  = 1'b1;
        @(negedge clk);
        while (!wr_ack && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!wr_ack) check("wr_timeout", 80'(0), 80'(1));
        else if (store) sb.push_back(w);
        @(posedge clk);
        #1;
        wr_req = 1'b0;
    endtask

    task automatic wait_reads(input int target);
        int t = 0;
        while (rd_count < target && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("rd_wait", 80'(rd_count >= target), 80'(1));
    endtask

    initial begin
        resetn  = 1'b0;
        wr_req  = 1'b1;
        rd_req  = 1'b1;
        wr_data = mk(1'b1, 64'h1);
        #12;
        check("rst_wack", 80'(wr_ack), 80'(0));
        check("rst_rack", 80'(rd_ack), 80'(0));
        @(posedge clk);
        #1;
        resetn = 1'b1;
        wr_req = 1'b0;

        // 3-word frame with the reader already requesting.
        check("t1_rack_w0", 80'(rd_ack), 80'(0));
        send_word(mk(1'b0, 64'h1001), 1'b1);
        check("t1_rack_w1", 80'(rd_ack), 80'(0));
        send_word(mk(1'b0, 64'h1002), 1'b1);
        check("t1_rack_w2", 80'(rd_ack), 80'(0));
        send_word(mk(1'b1, 64'h1003), 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t1_rack_burst", 80'(rd_ack), 80'(1));
        end
        @(negedge clk);
        check("t1_rack_done", 80'(rd_ack), 80'(0));

        // Exactly DEPTH words: stored, buffer full, then drained.
        @(posedge clk);
        #1;
        rd_req = 1'b0;
        for (int i = 1; i <= 64; i++) send_word(mk(i == 64, 64'h2000 + 64'(i)), 1'b1);
        wr_data = mk(1'b0, 64'hDEAD);
        wr_req  = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("t2_full_wack", 80'(wr_ack), 80'(0));
        end
        @(posedge clk);
        #1;
        wr_req = 1'b0;
        rd_req = 1'b1;
        wait_reads(rd_count + 64);
        @(posedge clk);
        #1;
        rd_req = 1'b0;

        // 65-word frame: oversize, dropped, nothing readable.
        for (int i = 1; i <= 65; i++) send_word(mk(i == 65, 64'h3000 + 64'(i)), 1'b0);
        rd_req = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("t3_no_read", 80'(rd_ack), 80'(0));
        end
`ifdef TX_FRAME_BUFFER_STATS_EN
        check("t3_drop_count", 80'(drop_count), 80'(1));
`endif
        @(posedge clk);
        #1;
        send_word(mk(1'b0, 64'h3101), 1'b1);
        send_word(mk(1'b1, 64'h3102), 1'b1);
        wait_reads(rd_count + 2);
        @(posedge clk);
        #1;
        rd_req = 1'b0;

        // Commit of frame A coincides with reading frame B's last word.
        send_word(mk(1'b0, 64'h4B00), 1'b1);
        send_word(mk(1'b1, 64'h4B01), 1'b1);
        send_word(mk(1'b0, 64'h4A00), 1'b1);
        send_word(mk(1'b0, 64'h4A01), 1'b1);
        rd_req = 1'b1;
        @(posedge clk);
        #1;
        wr_data = mk(1'b1, 64'h4A02);
        wr_req  = 1'b1;
        @(negedge clk);
        check("t4_rack_blast", 80'(rd_ack), 80'(1));
        check("t4_rdata_blast", 80'(rd_data), 80'(mk(1'b1, 64'h4B01)));
        check("t4_wack_alast", 80'(wr_ack), 80'(1));
        if (wr_ack) sb.push_back(wr_data);
        @(posedge clk);
        #1;
        wr_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4_rack_a", 80'(rd_ack), 80'(1));
        end
        @(negedge clk);
        check("t4_rack_end", 80'(rd_ack), 80'(0));
        @(posedge clk);
        #1;
        rd_req = 1'b0;

        // Reset mid-frame with one committed frame stored.
        send_word(mk(1'b0, 64'h5C00), 1'b0);
        send_word(mk(1'b1, 64'h5C01), 1'b0);
        send_word(mk(1'b0, 64'h5D00), 1'b0);
        send_word(mk(1'b0, 64'h5D01), 1'b0);
        rd_req  = 1'b1;
        wr_data = mk(1'b0, 64'h5D02);
        wr_req  = 1'b1;
        #1;
        check("t5_rack_pre", 80'(rd_ack), 80'(1));
        resetn = 1'b0;
        #1;
        check("t5_rack_rst", 80'(rd_ack), 80'(0));
        check("t5_wack_rst", 80'(wr_ack), 80'(0));
        @(negedge clk);
        wr_req = 1'b0;
        resetn = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("t5_rack_after", 80'(rd_ack), 80'(0));
        end
        @(posedge clk);
        #1;
        send_word(mk(1'b0, 64'h5E00), 1'b1);
        send_word(mk(1'b0, 64'h5E01), 1'b1);
        send_word(mk(1'b1, 64'h5E02), 1'b1);
        wait_reads(rd_count + 3);
        @(negedge clk);
        check("sb_empty", 80'(sb.size()), 80'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
